// File: rtl/cla_nibble_serial_adder_ctrl.sv
// Nibble-serial add/subtract sequencer around one shared 4-bit carry-look-ahead slice.
// Operands are processed LSB nibble first, and the slice carry is registered between nibbles.
module cla_nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             busy
);

  // state  | meaning
  // S_IDLE | ready for an operand pair
  // S_RUN  | one nibble through the slice per clock
  // S_DONE | result presented until the consumer accepts it
  localparam int NIB = WIDTH / 4;
  localparam int CW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, res_q, res_nxt;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [3:0]       a_nib, b_nib, s_nib, g, p;
  logic [4:0]       c;
  logic             last_nib;
  logic             accept;

  assign accept   = in_valid && (state == S_IDLE);
  assign last_nib = (cnt_q == CW'(NIB - 1));

  always_comb begin
    a_nib = a_q[{cnt_q, 2'b00} +: 4];
    b_nib = b_q[{cnt_q, 2'b00} +: 4];
    g     = a_nib & b_nib;
    p     = a_nib ^ b_nib;
    c[0]  = carry_q;
    c[1]  = g[0] | (p[0] & c[0]);
    c[2]  = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]  = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    c[4]  = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
          | (p[3] & p[2] & p[1] & p[0] & c[0]);
    s_nib = p ^ c[3:0];
    res_nxt = res_q;
    res_nxt[{cnt_q, 2'b00} +: 4] = s_nib;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid)  state_nxt = S_RUN;
      S_RUN:   if (last_nib)  state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  // Result ports only move on the final nibble, so they keep the previous result until then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (accept) begin
      a_q     <= in_a;
      b_q     <= in_sub ? ~in_b : in_b;
      carry_q <= in_sub | in_cin;
      cnt_q   <= '0;
      res_q   <= '0;
    end else if (state == S_RUN) begin
      res_q   <= res_nxt;
      carry_q <= c[4];
      if (last_nib) begin
        out_sum  <= res_nxt;
        out_cout <= c[4];
        out_ovf  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (s_nib[3] != a_q[WIDTH-1]);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
